piece_scheduler: RTL and testbench
==================================

Name: piece_scheduler

Overview:
- Sequences the free-running 3-bit LFSR random source into a queue of tetromino types for the game controller.
- Discards out-of-range values and applies a one-shot reroll to suppress immediate repeats.
- Keeps a preview queue for the "next piece" display and hands pieces to the game FSM over a valid/ready handshake.
- Sits between the LFSR and the game-control FSM / VGA preview renderer.

Parameters:
- DEPTH, 3: preview queue depth (entries); legal range 2..4.
- NUM_TYPES, 7: number of piece types; accepted codes are 0..NUM_TYPES-1.
- WARMUP_CYCLES, 4: cycles after reset ignored while the LFSR loads its seed.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- rnd  in  3  LFSR output, sampled every cycle.
- flush  in  1  new game: empties the queue and restarts filling.
- piece_ready  in  1  game FSM accepts the head piece this cycle.
- piece_valid  out  1  head piece available.
- piece_type  out  3  head piece code; 0 when the queue is empty.
- preview  out  3*DEPTH  queue contents; entry k at bits [3k+2:3k]; entry 0 is the head; empty entries read 0.
- queue_count  out  3  number of valid entries, 0..DEPTH.
- discard_count  out  8  saturating count of discarded samples (debug).

Behaviour:
- Reset (asynchronous):
  - state=WARMUP; warm counter=0; queue, queue_count and last_piece cleared; last_valid=0; reroll_used=0; discard_count=0.
  - piece_valid=0, piece_type=0, preview=0.
- States:
  - WARMUP: count WARMUP_CYCLES cycles, sampling nothing, then go to FILL.
  - FILL: sample rnd every cycle; go to FULL in the cycle after queue_count reaches DEPTH.
  - FULL: no sampling; return to FILL in the cycle after a pop.
- Candidate rule, evaluated once per FILL cycle when pre-pop queue_count < DEPTH:
  - rnd >= NUM_TYPES: discard; reroll_used unchanged.
  - last_valid=1 and rnd==last_piece and reroll_used=0: discard; set reroll_used=1.
  - Otherwise accept:
    - push rnd at index (queue_count minus 1 if a pop occurs this cycle, else queue_count);
    - last_piece<=rnd; last_valid<=1; reroll_used<=0.
  - Each discard increments discard_count, saturating at 255.
- Handshake:
  - piece_valid = (queue_count != 0) and state != WARMUP; combinational from registers.
  - A pop occurs when piece_valid and piece_ready are both high. Entries shift down by one; the vacated top entry is cleared to 0.
  - piece_type and preview are registered views of the queue, zero-latency relative to queue contents.
  - piece_type must hold stable while piece_valid=1 and piece_ready=0.
  - piece_ready while piece_valid=0 is ignored.
- Simultaneous pop and push: both happen in the same cycle; net queue_count is unchanged.
- Push with pre-pop count == DEPTH: no sample is taken (FULL state), even if a pop occurs that cycle.
- Accepted latency: a pushed value appears on preview in the next cycle. When the queue was empty, piece_valid rises the cycle after acceptance.
- flush (synchronous, highest priority after reset):
  - clears queue, queue_count, last_valid and reroll_used; goes to FILL (not WARMUP).
  - No pop occurs in the flush cycle, even if piece_ready=1.
  - discard_count is retained.
- Reset asserted mid-fill or mid-handshake: everything is cleared immediately; any pending pop is lost.

Decomposition:
- Shared package tetris_pkg:
  - piece code width PIECE_W=3;
  - named piece constants PIECE_I..PIECE_Z (0..6);
  - state encoding WARMUP=2'd0, FILL=2'd1, FULL=2'd2.
- One natural sub-module, piece_queue: shift-register FIFO of DEPTH entries with simultaneous push/pop and a flattened preview output.
- The accept/reroll logic and the FSM stay in piece_scheduler.

Test Plan:
- Warmup and fill: reset, then drive rnd=2,5,1 from cycle 0.
  - Samples during the first 4 cycles are ignored.
  - After warmup, with rnd=2,5,1 on consecutive cycles: preview={1,5,2} (entry0=2), queue_count=3, piece_valid=1, piece_type=2.
- Reroll: in FILL, last_piece=3, drive rnd=3,3.
  - First 3 is discarded (reroll_used=1); second 3 is accepted.
  - discard_count increments by 1.
- Out of range: drive rnd=7 for 5 cycles.
  - No push; discard_count +5; reroll_used unchanged.
  - Then rnd=4 is pushed.
- Backpressure and simultaneous ops:
  - Hold piece_ready=0 for 10 cycles: piece_type stays stable at the head value.
  - Queue of 2 entries {6,0}, pop with a same-cycle accepted rnd=4: queue becomes {0,4}, queue_count=2.
- Full boundary: queue full {1,2,3}, pop with rnd=5 in the same cycle.
  - 5 is not sampled; queue becomes {2,3}.
  - Next cycle state=FILL and samples resume.
- Flush and async reset:
  - flush with piece_ready=1: no pop; queue_count=0 next cycle; piece_valid=0; state=FILL.
  - reset pulsed mid-cycle: outputs go to 0 before the next clock edge.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared piece-code definitions and scheduler state encoding for the tetris datapath.
package tetris_pkg;

    localparam int PIECE_W = 3;

    localparam logic [PIECE_W-1:0] PIECE_I = 3'd0;
    localparam logic [PIECE_W-1:0] PIECE_J = 3'd1;
    localparam logic [PIECE_W-1:0] PIECE_L = 3'd2;
    localparam logic [PIECE_W-1:0] PIECE_O = 3'd3;
    localparam logic [PIECE_W-1:0] PIECE_S = 3'd4;
    localparam logic [PIECE_W-1:0] PIECE_T = 3'd5;
    localparam logic [PIECE_W-1:0] PIECE_Z = 3'd6;

    typedef enum logic [1:0] {
        WARMUP = 2'd0,
        FILL   = 2'd1,
        FULL   = 2'd2
    } sched_state_e;

    function automatic logic piece_in_range(input logic [PIECE_W-1:0] code, input int num_types);
        return int'(code) < num_types;
    endfunction

endpackage

// File: rtl/piece_queue.sv
// Shift-register FIFO of piece codes; head at entry 0, same-cycle push and pop allowed.
import tetris_pkg::*;

module piece_queue #(
    parameter int DEPTH = 3,
    parameter int W     = PIECE_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [W-1:0]       din_i,
    output logic [W-1:0]       head_o,
    output logic [W*DEPTH-1:0] preview_o,
    output logic [2:0]         count_o
);

    logic [W-1:0] ent_q [DEPTH];
    logic [W-1:0] ent_d [DEPTH];
    logic [2:0]   count_q, count_d;
    logic [2:0]   wr_idx;

    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            ent_d[k] = ent_q[k];
        end
        count_d = count_q;
        wr_idx  = count_q - {2'b00, pop_i};

        if (clr_i) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                ent_d[k] = '0;
            end
            count_d = '0;
        end else begin
            if (pop_i) begin
                for (int unsigned k = 0; k + 1 < DEPTH; k++) begin
                    ent_d[k] = ent_q[k+1];
                end
                ent_d[DEPTH-1] = '0;
            end
            // Write slot is computed against the post-shift layout so push+pop keeps order.
            if (push_i) begin
                for (int unsigned k = 0; k < DEPTH; k++) begin
                    if (wr_idx == 3'(k)) begin
                        ent_d[k] = din_i;
                    end
                end
            end
            count_d = count_q + {2'b00, push_i} - {2'b00, pop_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                ent_q[k] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                ent_q[k] <= ent_d[k];
            end
            count_q <= count_d;
        end
    end

    always_comb begin
        preview_o = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            preview_o[W*k +: W] = ent_q[k];
        end
    end

    assign head_o  = ent_q[0];
    assign count_o = count_q;

endmodule

// File: rtl/piece_scheduler.sv
// Turns raw LFSR samples into a queue of tetromino codes with range filtering,
// one-shot repeat reroll and a valid/ready hand-off to the game FSM.
import tetris_pkg::*;

module piece_scheduler #(
    parameter int DEPTH         = 3,
    parameter int NUM_TYPES     = 7,
    parameter int WARMUP_CYCLES = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [PIECE_W-1:0]       rnd,
    input  logic                     flush,
    input  logic                     piece_ready,
    output logic                     piece_valid,
    output logic [PIECE_W-1:0]       piece_type,
    output logic [PIECE_W*DEPTH-1:0] preview,
    output logic [2:0]               queue_count,
    output logic [7:0]               discard_count
);

    localparam logic [2:0] DEPTH_C   = 3'(DEPTH);
    localparam logic [7:0] WARM_LAST = 8'(WARMUP_CYCLES - 1);

    sched_state_e       state_q, state_d;
    logic [7:0]         warm_q, warm_d;
    logic [7:0]         disc_q, disc_d;
    logic [PIECE_W-1:0] last_piece_q, last_piece_d;
    logic               last_valid_q, last_valid_d;
    logic               reroll_q, reroll_d;

    logic       pop, push, sample, out_of_range, repeat_hit, discard;
    logic [2:0] count_q, count_next;

    piece_queue #(
        .DEPTH (DEPTH),
        .W     (PIECE_W)
    ) u_queue (
        .clk_i     (clock),
        .rst_i     (reset),
        .clr_i     (flush),
        .push_i    (push),
        .pop_i     (pop),
        .din_i     (rnd),
        .head_o    (piece_type),
        .preview_o (preview),
        .count_o   (count_q)
    );

    assign queue_count   = count_q;
    assign discard_count = disc_q;
    assign piece_valid   = (count_q != '0) && (state_q != WARMUP);

    always_comb begin
        pop          = piece_valid && piece_ready && !flush;
        sample       = (state_q == FILL) && !flush && (count_q < DEPTH_C);
        out_of_range = !piece_in_range(rnd, NUM_TYPES);
        repeat_hit   = last_valid_q && (rnd == last_piece_q) && !reroll_q;
        push         = sample && !out_of_range && !repeat_hit;
        discard      = sample && !push;
        count_next   = count_q + {2'b00, push} - {2'b00, pop};
    end

    always_comb begin
        state_d      = state_q;
        warm_d       = warm_q;
        disc_d       = disc_q;
        last_piece_d = last_piece_q;
        last_valid_d = last_valid_q;
        reroll_d     = reroll_q;

        if (flush) begin
            state_d      = FILL;
            last_valid_d = 1'b0;
            reroll_d     = 1'b0;
        end else begin
            unique case (state_q)
                WARMUP: begin
                    if (warm_q == WARM_LAST) state_d = FILL;
                    else                     warm_d  = warm_q + 8'd1;
                end
                // Entering FULL on the post-update count means FILL never sits on a full queue.
                FILL:    if (count_next == DEPTH_C) state_d = FULL;
                FULL:    if (pop) state_d = FILL;
                default: state_d = WARMUP;
            endcase

            if (push) begin
                last_piece_d = rnd;
                last_valid_d = 1'b1;
                reroll_d     = 1'b0;
            end else if (discard && !out_of_range) begin
                reroll_d = 1'b1;
            end

            if (discard && disc_q != 8'hFF) begin
                disc_d = disc_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= WARMUP;
            warm_q       <= '0;
            disc_q       <= '0;
            last_piece_q <= '0;
            last_valid_q <= 1'b0;
            reroll_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            warm_q       <= warm_d;
            disc_q       <= disc_d;
            last_piece_q <= last_piece_d;
            last_valid_q <= last_valid_d;
            reroll_q     <= reroll_d;
        end
    end

endmodule

// File: tb/tb_piece_scheduler.sv
// Self-checking bench for piece_scheduler: vector table, directed corner sequences
// and randomized traffic against a queue-based reference model.
module tb_piece_scheduler;

    localparam int DEPTH = 3;

    logic       clock;
    logic       reset;
    logic [2:0] rnd;
    logic       flush;
    logic       piece_ready;
    logic       piece_valid;
    logic [2:0] piece_type;
    logic [8:0] preview;
    logic [2:0] queue_count;
    logic [7:0] discard_count;

    int checks = 0;
    int errors = 0;

    piece_scheduler #(
        .DEPTH         (DEPTH),
        .NUM_TYPES     (7),
        .WARMUP_CYCLES (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .rnd           (rnd),
        .flush         (flush),
        .piece_ready   (piece_ready),
        .piece_valid   (piece_valid),
        .piece_type    (piece_type),
        .preview       (preview),
        .queue_count   (queue_count),
        .discard_count (discard_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: queue of accepted codes plus the filter's memory.
    int m_q[$];
    int m_wait;
    int m_last;
    bit m_lastv;
    bit m_reroll;
    int m_disc;

    task automatic model_reset();
        m_q.delete();
        m_wait   = 4;
        m_last   = 0;
        m_lastv  = 0;
        m_reroll = 0;
        m_disc   = 0;
    endtask

    task automatic model_step();
        bit valid;
        bit take;
        bit acc;
        int r;
        valid = (m_q.size() != 0) && (m_wait == 0);
        r     = int'(rnd);
        acc   = 0;
        if (flush) begin
            m_q.delete();
            m_lastv  = 0;
            m_reroll = 0;
            m_wait   = 0;
        end else begin
            take = (m_wait == 0) && (m_q.size() < DEPTH);
            if (m_wait > 0) m_wait--;
            if (take) begin
                if (r >= 7) begin
                    if (m_disc < 255) m_disc++;
                end else if (m_lastv && r == m_last && !m_reroll) begin
                    m_reroll = 1;
                    if (m_disc < 255) m_disc++;
                end else begin
                    acc = 1;
                end
            end
            if (valid && piece_ready) void'(m_q.pop_front());
            if (acc) begin
                m_q.push_back(r);
                m_last   = r;
                m_lastv  = 1;
                m_reroll = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model();
        logic [8:0] p;
        int         head;
        p    = '0;
        head = 0;
        for (int k = 0; k < m_q.size(); k++) p[3*k +: 3] = 3'(m_q[k]);
        if (m_q.size() != 0) head = m_q[0];
        check("model_valid", 32'(piece_valid), 32'((m_q.size() != 0) && (m_wait == 0)));
        check("model_type", 32'(piece_type), 32'(head));
        check("model_preview", 32'(preview), 32'(p));
        check("model_count", 32'(queue_count), 32'(m_q.size()));
        check("model_discard", 32'(discard_count), 32'(m_disc));
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        check_model();
    endtask

    typedef struct {
        logic [2:0] rnd;
        logic       flush;
        logic       ready;
        logic       exp_valid;
        logic [2:0] exp_type;
        logic [2:0] exp_count;
        logic [8:0] exp_prev;
        logic [7:0] exp_disc;
    } vec_t;

    vec_t vecs[14];
    int   base;

    initial begin
        vecs[0]  = '{3'd6, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 9'h000, 8'd0};
        vecs[1]  = '{3'd6, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 9'h000, 8'd0};
        vecs[2]  = '{3'd6, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 9'h000, 8'd0};
        vecs[3]  = '{3'd6, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 9'h000, 8'd0};
        vecs[4]  = '{3'd2, 1'b0, 1'b0, 1'b1, 3'd2, 3'd1, 9'h002, 8'd0};
        vecs[5]  = '{3'd5, 1'b0, 1'b0, 1'b1, 3'd2, 3'd2, 9'h02A, 8'd0};
        vecs[6]  = '{3'd1, 1'b0, 1'b0, 1'b1, 3'd2, 3'd3, 9'h06A, 8'd0};
        vecs[7]  = '{3'd7, 1'b0, 1'b0, 1'b1, 3'd2, 3'd3, 9'h06A, 8'd0};
        vecs[8]  = '{3'd3, 1'b0, 1'b1, 1'b1, 3'd5, 3'd2, 9'h00D, 8'd0};
        vecs[9]  = '{3'd1, 1'b0, 1'b0, 1'b1, 3'd5, 3'd2, 9'h00D, 8'd1};
        vecs[10] = '{3'd1, 1'b0, 1'b0, 1'b1, 3'd5, 3'd3, 9'h04D, 8'd1};
        vecs[11] = '{3'd1, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 9'h000, 8'd1};
        vecs[12] = '{3'd7, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 9'h000, 8'd2};
        vecs[13] = '{3'd4, 1'b0, 1'b0, 1'b1, 3'd4, 3'd1, 9'h004, 8'd2};

        reset       = 1'b1;
        flush       = 1'b0;
        piece_ready = 1'b0;
        rnd         = 3'd0;
        #3;
        check("rst_valid", 32'(piece_valid), 32'd0);
        check("rst_preview", 32'(preview), 32'd0);
        #9;
        reset = 1'b0;
        model_reset();

        for (int i = 0; i < 14; i++) begin
            rnd         = vecs[i].rnd;
            flush       = vecs[i].flush;
            piece_ready = vecs[i].ready;
            tick();
            check($sformatf("tbl%0d_valid", i), 32'(piece_valid), 32'(vecs[i].exp_valid));
            check($sformatf("tbl%0d_type", i), 32'(piece_type), 32'(vecs[i].exp_type));
            check($sformatf("tbl%0d_count", i), 32'(queue_count), 32'(vecs[i].exp_count));
            check($sformatf("tbl%0d_preview", i), 32'(preview), 32'(vecs[i].exp_prev));
            check($sformatf("tbl%0d_discard", i), 32'(discard_count), 32'(vecs[i].exp_disc));
        end
        flush       = 1'b0;
        piece_ready = 1'b0;

        // Same-cycle pop and push on a two-entry queue.
        flush = 1'b1; tick(); flush = 1'b0;
        rnd = 3'd6; tick();
        rnd = 3'd0; tick();
        rnd = 3'd4; piece_ready = 1'b1; tick(); piece_ready = 1'b0;
        check("pp_preview", 32'(preview), 32'h020);
        check("pp_count", 32'(queue_count), 32'd2);
        check("pp_type", 32'(piece_type), 32'd0);
        check("pp_valid", 32'(piece_valid), 32'd1);

        // Pop while full: the concurrent sample is skipped, sampling resumes next cycle.
        flush = 1'b1; tick(); flush = 1'b0;
        rnd = 3'd1; tick();
        rnd = 3'd2; tick();
        rnd = 3'd3; tick();
        rnd = 3'd5; piece_ready = 1'b1; tick(); piece_ready = 1'b0;
        check("full_pop_preview", 32'(preview), 32'h01A);
        check("full_pop_count", 32'(queue_count), 32'd2);
        rnd = 3'd5; tick();
        check("full_resume_preview", 32'(preview), 32'h15A);
        check("full_resume_count", 32'(queue_count), 32'd3);

        // One-shot reroll of an immediate repeat.
        flush = 1'b1; tick(); flush = 1'b0;
        base = m_disc;
        rnd = 3'd3; tick();
        rnd = 3'd3; tick();
        check("reroll_first_count", 32'(queue_count), 32'd1);
        rnd = 3'd3; tick();
        check("reroll_discard", 32'(discard_count), 32'(base + 1));
        check("reroll_count", 32'(queue_count), 32'd2);
        check("reroll_preview", 32'(preview), 32'h01B);

        // Out-of-range samples.
        rnd = 3'd7;
        for (int i = 0; i < 5; i++) tick();
        check("oor_discard", 32'(discard_count), 32'(base + 6));
        check("oor_count", 32'(queue_count), 32'd2);
        rnd = 3'd4; tick();
        check("oor_push_count", 32'(queue_count), 32'd3);
        check("oor_push_preview", 32'(preview), 32'h11B);

        // Backpressure: head must not move.
        piece_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rnd = 3'($urandom_range(0, 7));
            tick();
            check($sformatf("hold%0d_type", i), 32'(piece_type), 32'd3);
            check($sformatf("hold%0d_valid", i), 32'(piece_valid), 32'd1);
        end

        // Discard counter saturation.
        flush = 1'b1; tick(); flush = 1'b0;
        rnd = 3'd7;
        for (int i = 0; i < 260; i++) tick();
        check("sat_discard", 32'(discard_count), 32'd255);

        // Asynchronous reset between edges with a pop pending.
        rnd = 3'd2; tick();
        piece_ready = 1'b1;
        #3 reset = 1'b1;
        #1;
        check("arst_valid", 32'(piece_valid), 32'd0);
        check("arst_type", 32'(piece_type), 32'd0);
        check("arst_preview", 32'(preview), 32'd0);
        check("arst_count", 32'(queue_count), 32'd0);
        check("arst_discard", 32'(discard_count), 32'd0);
        model_reset();
        #2 reset = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if (m_lastv && $urandom_range(0, 3) == 0) rnd = 3'(m_last);
            else                                      rnd = 3'($urandom_range(0, 7));
            piece_ready = 1'($urandom_range(0, 1));
            flush       = ($urandom_range(0, 39) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
